// File: rtl/swc_pkg.sv
// Shared constants and types for the SwitchMCU front end and execute units.
package swc_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] SWC_RESET_PC = 32'h0000_0000;

    localparam int FLUSH_FETCH = 0;
    localparam int FLUSH_DEC   = 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; head is read straight from storage.
module ifu_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         hclk,
    input  logic                         hrstn,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    input  logic                         trim,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // clear and trim win over push/pop; trim keeps only the current head
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else if (trim) begin
            if (!empty) begin
                wr_ptr <= ptr_inc(rd_ptr);
                count  <= CW'(1);
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_fetch_swc.sv
// Instruction fetch unit: fetch PC, request/grant/response memory port, 2-entry
// instruction queue toward decode, redirect/flush handling and head-wait counter.
module ifu_fetch_swc
    import swc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = SWC_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        pc_write,
    input  logic [31:0] pc_wdata,
    input  logic [1:0]  flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        dec_ready,
    output logic [3:0]  cycle_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   q_cnt;
    logic            q_full;
    logic            q_empty;
    logic [2*XLEN-1:0] q_head;
    fetch_entry_t    head;

    logic redirect, hs, space, req_raw, granted, resp, drop, push;
    logic q_clear, q_trim;

    assign redirect = pc_write | flush[FLUSH_FETCH] | flush[FLUSH_DEC];
    assign hs       = if_valid & dec_ready;
    assign target   = pc_wdata & 32'hFFFF_FFFC;

    // A grant that lands while a redirect drops imem_req still counts: the
    // memory may have sampled the request, so its response must be discarded.
    assign space    = ({1'b0, q_cnt} + {1'b0, out_cnt}) < (CW + 1)'(DEPTH);
    assign req_raw  = hrstn & space;
    assign imem_req = req_raw & ~redirect;
    assign granted  = imem_gnt & req_raw;

    // Responses with nothing outstanding (e.g. left over from before reset) are ignored
    assign resp     = imem_rvalid & (out_cnt != '0);
    assign drop     = resp & (discard_cnt != '0);
    assign push     = resp & ~drop & ~redirect & ~q_full;
    assign out_next = out_cnt + CW'(granted) - CW'(resp);

    assign q_clear  = redirect & (flush[FLUSH_DEC] | pc_write | hs);
    assign q_trim   = redirect & ~q_clear;

    assign imem_addr = fetch_pc;
    assign head      = q_head;
    assign if_valid  = ~q_empty;
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;

    ifu_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .hclk      (hclk),
        .hrstn     (hrstn),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (hs),
        .clear     (q_clear),
        .trim      (q_trim),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_cnt)
    );

    // resp_pc is the PC of the next response that will be kept
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            out_cnt     <= '0;
            discard_cnt <= '0;
            cycle_cnt   <= '0;
        end else begin
            out_cnt <= out_next;

            if (redirect) discard_cnt <= out_next;
            else          discard_cnt <= discard_cnt - CW'(drop);

            if (pc_write)                  fetch_pc <= target;
            else if (granted && !redirect) fetch_pc <= fetch_pc + 32'd4;

            if (pc_write)      resp_pc <= target;
            else if (redirect) resp_pc <= fetch_pc;
            else if (push)     resp_pc <= resp_pc + 32'd4;

            if (hs || redirect || !if_valid) cycle_cnt <= '0;
            else if (cycle_cnt != 4'hF)      cycle_cnt <= cycle_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_swc.sv
// Scoreboard bench for ifu_fetch_swc: transaction-level model of queue, outstanding
// requests and redirects; a negedge monitor compares each delivered instruction.
module tb_ifu_fetch_swc;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        pc_write = 1'b0;
    logic [31:0] pc_wdata = '0;
    logic [1:0]  flush = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        dec_ready = 1'b0;
    logic [3:0]  cycle_cnt;

    always #5 hclk = ~hclk;

    ifu_fetch_swc #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .hclk        (hclk),
        .hrstn       (hrstn),
        .pc_write    (pc_write),
        .pc_wdata    (pc_wdata),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .dec_ready   (dec_ready),
        .cycle_cnt   (cycle_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] act;
        bit          keep;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] expq[$];
    logic [31:0] m_fpc = '0;
    int          m_cc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    bit          s_pw, s_gnt, s_rv, s_rdy, s_force, s_stray;
    logic [31:0] s_pc;
    logic [1:0]  s_fl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic reset_outputs_chk();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    endtask

    // Monitor: compares presence, head-wait count and every delivered instruction
    always @(negedge hclk) begin
        if (hrstn) begin
            chk("if_valid", 32'(if_valid), 32'(expq.size() > 0));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cc));
            if (dec_ready && expq.size() > 0) begin
                chk("if_pc", if_pc, expq[0]);
                chk("if_instr", if_instr, expq[0] ^ K);
                void'(expq.pop_front());
            end
        end
    end

    // One clock cycle: drive knobs at posedge+1, grant at posedge+2, update model at next posedge+1
    task automatic step();
        bit redir, hs, vnow, acc, rv;
        logic [31:0] act;
        redir       = s_pw || (s_fl != 2'b00);
        pc_write    = s_pw;
        pc_wdata    = s_pc;
        flush       = s_fl;
        dec_ready   = s_rdy;
        rv          = s_stray || (s_rv && pend.size() > 0);
        imem_rvalid = rv;
        imem_rdata  = (pend.size() > 0) ? (pend[0].act ^ K) : $urandom;
        imem_gnt    = 1'b0;
        #1;
        chk("imem_req", 32'(imem_req), 32'(!redir && (expq.size() + pend.size() < 2)));
        acc      = s_gnt && (imem_req || s_force);
        imem_gnt = acc;
        act      = imem_addr;
        if (acc) chk("imem_addr", imem_addr, m_fpc);
        hs   = s_rdy && expq.size() > 0;
        vnow = expq.size() > 0;
        @(posedge hclk);
        #1;
        if (rv && pend.size() > 0) begin
            pend_t p;
            p = pend.pop_front();
            if (p.keep && !redir) expq.push_back(p.pc);
        end
        if (redir) begin
            if (hs || s_fl[1] || s_pw) expq.delete();
            else while (expq.size() > 1) void'(expq.pop_back());
            foreach (pend[i]) pend[i].keep = 1'b0;
        end
        if (acc) pend.push_back('{pc: m_fpc, act: act, keep: !redir});
        if (s_pw) m_fpc = s_pc & 32'hFFFF_FFFC;
        else if (acc && !redir) m_fpc = m_fpc + 32'd4;
        m_cc = (hs || redir || !vnow) ? 0 : ((m_cc == 15) ? 15 : m_cc + 1);
    endtask

    task automatic fill_queue(input string nm);
        s_rdy = 0; s_gnt = 1; s_rv = 1;
        for (int i = 0; i < 20 && !(expq.size() == 2 && pend.size() == 0); i++) step();
        chk(nm, 32'(expq.size()), 32'd2);
    endtask

    task automatic drain(input string nm);
        s_gnt = 0; s_rv = 1; s_rdy = 1; s_pw = 0; s_fl = 0;
        for (int i = 0; i < 20 && (expq.size() + pend.size()) != 0; i++) step();
        chk(nm, 32'(expq.size() + pend.size()), 32'd0);
    endtask

    initial begin
        s_pw = 0; s_gnt = 0; s_rv = 0; s_rdy = 0; s_force = 0; s_stray = 0;
        s_pc = '0; s_fl = '0;
        #1;
        reset_outputs_chk();
        @(posedge hclk);
        #3 hrstn = 1'b1;
        @(posedge hclk);
        #1;

        // streaming
        s_gnt = 1; s_rv = 1; s_rdy = 1;
        repeat (30) step();

        // backpressure, then release
        s_rdy = 0;
        repeat (20) step();
        s_rdy = 1;
        repeat (12) step();

        // jump with two responses outstanding
        s_rv = 0;
        for (int i = 0; i < 20 && !(pend.size() == 2 && expq.size() == 0); i++) step();
        chk("jump_setup", 32'(pend.size()), 32'd2);
        s_pw = 1; s_pc = 32'h0000_0103;
        step();
        s_pw = 0; s_rv = 1;
        chk("jump_addr", imem_addr, 32'h0000_0100);
        repeat (12) step();

        // flush[0]: head survives
        fill_queue("fill_flush01");
        s_fl = 2'b01;
        step();
        s_fl = 2'b00;
        chk("flush01_valid", 32'(if_valid), 32'd1);
        s_rdy = 1;
        repeat (8) step();

        // flush[1]: head killed
        fill_queue("fill_flush11");
        s_fl = 2'b11;
        step();
        s_fl = 2'b00;
        chk("flush11_valid", 32'(if_valid), 32'd0);
        s_rdy = 1;
        repeat (8) step();

        // handshake and pc_write together
        fill_queue("fill_hs_jump");
        s_rdy = 1; s_pw = 1; s_pc = 32'h0000_0040;
        step();
        s_pw = 0;
        repeat (10) step();

        // grant and pc_write together
        drain("drain_gnt_jump");
        s_pw = 1; s_pc = 32'h0000_0200; s_gnt = 1; s_force = 1;
        step();
        s_pw = 0; s_force = 0;
        chk("gnt_jump_addr", imem_addr, 32'h0000_0200);
        repeat (10) step();

        // randomized traffic
        repeat (300) begin
            s_pw  = ($urandom_range(0, 19) == 0);
            s_pc  = $urandom & 32'h0000_0FFF;
            s_fl  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s_rdy = ($urandom_range(0, 3) != 0);
            s_rv  = ($urandom_range(0, 2) != 0);
            s_gnt = ($urandom_range(0, 2) != 0);
            step();
        end
        s_pw = 0; s_fl = 0;

        // reset with two requests outstanding
        drain("drain_pre_reset");
        s_rv = 0; s_rdy = 0; s_gnt = 1;
        for (int i = 0; i < 10 && pend.size() != 2; i++) step();
        chk("reset_setup", 32'(pend.size()), 32'd2);
        pc_write = 0; flush = 0; imem_gnt = 0; imem_rvalid = 0; dec_ready = 0;
        #2 hrstn = 1'b0;
        #1;
        reset_outputs_chk();
        pend.delete();
        expq.delete();
        m_fpc = 32'h0;
        m_cc  = 0;
        @(posedge hclk);
        @(posedge hclk);
        #3 hrstn = 1'b1;
        @(posedge hclk);
        #1;
        s_gnt = 0; s_rv = 0; s_stray = 1;
        repeat (3) step();
        s_stray = 0;
        s_gnt = 1; s_rv = 1; s_rdy = 1;
        repeat (12) step();

        drain("final_drain");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch_swc.md
# ifu_fetch_swc

Instruction fetch unit for the SwitchMCU core. Holds the fetch PC, issues word requests to instruction memory over a request/grant/response interface, and buffers returned words in a 2-entry queue. Presents one instruction at a time to decode with a valid/ready handshake. Consumes the redirect (`pc_write`/`pc_wdata`) and `flush` outputs of the execute units (e.g. `exu_jump_swc`), and produces the `cycle_cnt` those units consume.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `DEPTH`, 2: instruction queue entries; also the limit on queued plus outstanding requests.

Ports:
- `hclk` in 1: clock. All logic on the rising edge.
- `hrstn` in 1: reset, asynchronous, active-low.
- `pc_write` in 1: redirect strobe from execute.
- `pc_wdata` in 32: redirect target. Bits [1:0] are ignored and forced to 0.
- `flush` in 2: [0] kills the queue and in-flight responses; [1] also kills the instruction currently presented to decode.
- `imem_req` out 1: fetch request. Held until granted.
- `imem_addr` out 32: word address of the request.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Responses return in order, at least 1 cycle after the grant.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: instruction available to decode.
- `if_instr` out 32: instruction word.
- `if_pc` out 32: PC of `if_instr`.
- `dec_ready` in 1: decode accepts this cycle.
- `cycle_cnt` out 4: cycles the head instruction has been presented. Saturates at 4'hF.

## Operation

- **Fetch.** `imem_req` asserts whenever queued entries plus outstanding requests < `DEPTH`, and no redirect is being applied this cycle.
  - On `imem_req && imem_gnt`: `fetch_pc` advances by 4, and the outstanding count increments.
- **Response.** On `imem_rvalid`, the outstanding count decrements.
  - If `discard_cnt > 0`: the word is dropped and `discard_cnt` decrements.
  - Otherwise: the word is pushed into the queue together with its PC. Each PC is tracked in order in a small PC FIFO or by a counter from the head.
- **Decode handshake.** `if_valid` is high when the queue is non-empty. A handshake (`if_valid && dec_ready`) pops the head.
- **Redirect.** A redirect is `pc_write` or any `flush` bit set.
  - `fetch_pc` becomes `pc_wdata`, but only when `pc_write` is set.
  - Queue entries behind the head are cleared.
  - The head is cleared if `flush[1]`, or if `pc_write` is set and the head is not handshaken this cycle.
  - `discard_cnt` is loaded with the outstanding count, including a request granted this same cycle, minus any response arriving this cycle.
- **Simultaneous events.**
  - Redirect and handshake in the same cycle: the handshake completes (the jump itself retires), then the flush applies.
  - Redirect and `imem_gnt` in the same cycle: that grant counts as outstanding and its response is discarded.
- **cycle_cnt.**
  - Clears to 0 on a handshake, on a redirect, or while `if_valid` is low.
  - Otherwise increments each cycle, saturating at 4'hF.
- **Reset mid-operation.** Outstanding responses after reset are not tracked; `imem_rvalid` received while the outstanding count is 0 is ignored.

## Timing

- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `cycle_cnt`=0, internal counters 0.
- **First request:** `imem_req`=1 in the first cycle after `hrstn` deasserts.
- **Response to decode:** `imem_rvalid` in cycle N gives `if_valid` in cycle N+1, since the queue output is registered.
- **Redirect latency:** redirect in cycle N gives `imem_req` with the new address in N+1.
  - With grant in N+1 and response in N+2, `if_valid` rises in N+3.
- **Queue full:** `imem_req` is held low. Fetch resumes in the cycle after a pop frees a slot.

## Structure

- **Shared package `swc_pkg`:**
  - `SWC_RESET_PC`.
  - Flush bit indices `FLUSH_FETCH`=0 and `FLUSH_DEC`=1.
  - Instruction/PC width constants (32).
- **Sub-module `ifu_fetch_fifo`:** a parameterised synchronous FIFO of {pc, instr} entries with push, pop, clear, full, empty and count.
- The top level holds `fetch_pc`, the outstanding and discard counters, and `cycle_cnt`.

## Test plan

- **Reset and streaming:** release reset, grant every cycle, respond 1 cycle later with data = address ^ 32'hA5A5A5A5, `dec_ready`=1 → `if_pc` sequence 0, 4, 8, ….
- **Backpressure:** `dec_ready`=0 for 20 cycles.
  - `imem_req` drops once the queue holds 2 entries.
  - `cycle_cnt` counts 0…15 and holds at 15.
  - After release, `if_pc` continues without gaps or duplicates.
- **Jump redirect:** `pc_write`=1, `pc_wdata`=32'h0000_0103 while 2 responses are outstanding.
  - Both stale words are dropped.
  - The next `imem_addr` is 32'h0000_0100, and the next `if_pc` is 32'h0000_0100.
- **Flush encodings:**
  - `flush`=2'b01 with a head instruction present → the head survives and queued entries are cleared.
  - `flush`=2'b11 → `if_valid`=0 in the next cycle.
- **Simultaneous events:**
  - Handshake and `pc_write` in the same cycle → the head is popped exactly once, and there is no duplicate fetch of the old stream.
  - Grant and `pc_write` in the same cycle → that response is discarded.
- **Reset mid-operation:** assert `hrstn`=0 with 2 requests outstanding → all outputs return to their reset values immediately, and stray `imem_rvalid` after release is ignored.
